mem_bus_if: RTL

- Memory bus interface stage. Sits directly downstream of the memory address source mux in the multi-cycle core.
- Takes the selected memory address plus store data, size and direction from the control FSM.
- Performs one valid/ready transaction on the external memory bus: byte-lane alignment, write strobes, load sign/zero extension, misalignment check and bus timeout.
- Returns a done or error pulse to the control FSM.

---
 rtl/mem_bus_if.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: memory bus interface stage of the multi-cycle core.
// Takes one access request (address, store data, size, direction) from the
// control FSM and runs it as a single valid/ready transaction on the external
// memory bus. The stage does byte-lane alignment, write-strobe generation,
// load sign/zero extension, the misalignment check and a bus timeout.
//
// Ports:
//   clk, rstn        clock; synchronous active-low reset
//   mem_addr/wd      byte address and right-aligned store data
//   mem_req          start access (sampled only in IDLE)
//   mem_we           1 = store, 0 = load
//   mem_size         00 byte, 01 half, 10 word, 11 illegal
//   mem_unsigned     zero-extend loads when 1
//   mem_rd           aligned, extended load data (held until next load)
//   mem_done/err     one-cycle completion / error pulses
//   bus_*            external valid/ready memory bus
module mem_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wd,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] mem_rd,
    output logic        mem_done,
    output logic        mem_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        waddr_q, waddr_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic               uns_q, uns_d;
    logic               we_q, we_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               valid_q, valid_d;
    logic [31:0]        rd_q, rd_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               misaligned;
    logic [3:0]         fmt_strb;
    logic [31:0]        fmt_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;

    // Alignment check on the incoming request
    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = mem_addr[0];
            SZ_WORD: misaligned = (mem_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane formatting: replicate data across lanes, strobe the target bytes
    always_comb begin
        fmt_strb = 4'b0000;
        fmt_data = 32'h0;
        if (mem_we) begin
            case (mem_size)
                SZ_BYTE: begin
                    fmt_data = {4{mem_wd[7:0]}};
                    fmt_strb = 4'b0001 << mem_addr[1:0];
                end
                SZ_HALF: begin
                    fmt_data = {2{mem_wd[15:0]}};
                    fmt_strb = mem_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    fmt_data = mem_wd;
                    fmt_strb = 4'b1111;
                end
            endcase
        end
    end

    // Load lane selection and extension from the registered offset/size
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_BUS;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        waddr_d = mem_addr[31:2];
                        size_d  = mem_size;
                        off_d   = mem_addr[1:0];
                        uns_d   = mem_unsigned;
                        we_d    = mem_we;
                        wstrb_d = fmt_strb;
                        wdata_d = fmt_data;
                    end
                end
            end
            S_BUS: begin
                // Ready wins over a timeout expiring in the same cycle
                if (bus_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rd_d = ld_ext;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd    = rd_q;
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign bus_valid = valid_q;
    assign bus_addr  = {waddr_q, 2'b00};
    assign bus_we    = we_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

endmodule
